// File: rtl/sent_rx_decoder.sv
// sent_rx_decoder: SENT line receiver. Measures falling-edge intervals in ticks,
// rebuilds status/data/CRC nibbles and reports a 32-bit frame word.
module sent_rx_decoder #(
  parameter int CLK_FREQ = 100000000,
  parameter int SYNC_TOL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sent_ctick_len,
  input  logic        sent_crc_mode,
  input  logic        sent_in,
  output logic        rx_frame_vld,
  output logic [31:0] rx_frame_data,
  output logic        rx_crc_err,
  output logic        rx_err,
  output logic        rx_sync_lock
);

  localparam int         CYC_PER_US = CLK_FREQ / 1000000;
  localparam logic [9:0] T_MAX      = 10'd1023;
  localparam logic [9:0] SYNC_LO    = 10'(56 - SYNC_TOL);
  localparam logic [9:0] SYNC_HI    = 10'(56 + SYNC_TOL);
  localparam logic [3:0] CRC_SEED   = 4'd5;

  typedef enum logic [2:0] {
    HUNT,
    STATUS,
    DATA,
    CRC_NIB,
    POST
  } state_t;

  function automatic logic [3:0] crc_tbl(input logic [3:0] i);
    logic [3:0] r;
    unique case (i)
      4'd0:  r = 4'd0;
      4'd1:  r = 4'd13;
      4'd2:  r = 4'd7;
      4'd3:  r = 4'd10;
      4'd4:  r = 4'd14;
      4'd5:  r = 4'd3;
      4'd6:  r = 4'd9;
      4'd7:  r = 4'd4;
      4'd8:  r = 4'd1;
      4'd9:  r = 4'd12;
      4'd10: r = 4'd6;
      4'd11: r = 4'd11;
      4'd12: r = 4'd15;
      4'd13: r = 4'd2;
      4'd14: r = 4'd8;
      4'd15: r = 4'd5;
    endcase
    return r;
  endfunction

  logic        s1, s2, s3, fe;
  logic [7:0]  len_r;
  logic        mode_r;
  logic        halt;
  logic [15:0] tick_cyc;
  logic [15:0] sub_cnt;
  logic [9:0]  tick_cnt;
  logic        wrap;

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [3:0]  crc, crc_nx;
  logic [3:0]  status_r, status_nx;
  logic [23:0] data_r, data_nx;
  logic [31:0] frame_nx;
  logic        lock_nx, vld_nx, crc_err_nx, err_nx;

  logic        nib_ok, sync_ok;
  logic [3:0]  nib, crc_fin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      fe <= 1'b0;
    end else begin
      s1 <= sent_in;
      s2 <= s1;
      s3 <= s2;
      fe <= s3 & ~s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r  <= 8'd0;
      mode_r <= 1'b0;
    end else begin
      len_r  <= sent_ctick_len;
      mode_r <= sent_crc_mode;
    end
  end

  assign halt = (sent_ctick_len != len_r) | (sent_crc_mode != mode_r) |
                (len_r == 8'd0);
  assign tick_cyc = 16'(int'(len_r) * CYC_PER_US);
  // >= keeps the counter bounded if the tick length shrinks
  assign wrap = (sub_cnt >= tick_cyc - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt  <= 16'd0;
      tick_cnt <= 10'd0;
    end else if (halt) begin
      sub_cnt  <= 16'd0;
      tick_cnt <= 10'd0;
    end else if (fe) begin
      sub_cnt  <= tick_cyc >> 1;
      tick_cnt <= 10'd0;
    end else if (wrap) begin
      sub_cnt <= 16'd0;
      if (tick_cnt != T_MAX)
        tick_cnt <= tick_cnt + 10'd1;
    end else begin
      sub_cnt <= sub_cnt + 16'd1;
    end
  end

  assign nib_ok  = (tick_cnt >= 10'd12) && (tick_cnt <= 10'd27);
  assign sync_ok = (tick_cnt >= SYNC_LO) && (tick_cnt <= SYNC_HI);
  assign nib     = 4'(tick_cnt - 10'd12);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    crc_nx     = crc;
    status_nx  = status_r;
    data_nx    = data_r;
    frame_nx   = rx_frame_data;
    lock_nx    = rx_sync_lock;
    vld_nx     = 1'b0;
    crc_err_nx = 1'b0;
    err_nx     = 1'b0;
    crc_fin    = mode_r ? crc_tbl(crc) : crc;
    if (halt) begin
      state_nx = HUNT;
      lock_nx  = 1'b0;
    end else if (fe) begin
      unique case (state)
        HUNT: begin
          if (sync_ok) begin
            state_nx = STATUS;
            lock_nx  = 1'b1;
            crc_nx   = CRC_SEED;
          end
        end
        POST: begin
          if (sync_ok) begin
            state_nx = STATUS;
            lock_nx  = 1'b1;
            crc_nx   = CRC_SEED;
          end else begin
            state_nx = HUNT;
          end
        end
        default: begin
          if (!nib_ok) begin
            err_nx  = 1'b1;
            lock_nx = 1'b0;
            if (sync_ok) begin
              state_nx = STATUS;
              crc_nx   = CRC_SEED;
            end else begin
              state_nx = HUNT;
            end
          end else begin
            unique case (state)
              STATUS: begin
                status_nx = nib;
                idx_nx    = 3'd0;
                state_nx  = DATA;
              end
              DATA: begin
                // shift in so nibble 1 ends up in the top position
                data_nx = {data_r[19:0], nib};
                crc_nx  = nib ^ crc_tbl(crc);
                if (idx == 3'd5)
                  state_nx = CRC_NIB;
                else
                  idx_nx = idx + 3'd1;
              end
              CRC_NIB: begin
                frame_nx   = {status_r, data_r, nib};
                vld_nx     = 1'b1;
                crc_err_nx = (crc_fin != nib);
                state_nx   = POST;
              end
              default: state_nx = HUNT;
            endcase
          end
        end
      endcase
    end else if (tick_cnt == T_MAX) begin
      unique case (state)
        HUNT: lock_nx = 1'b0;
        POST: begin
          state_nx = HUNT;
          lock_nx  = 1'b0;
        end
        default: begin
          state_nx = HUNT;
          lock_nx  = 1'b0;
          err_nx   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      idx           <= 3'd0;
      crc           <= 4'd0;
      status_r      <= 4'd0;
      data_r        <= 24'd0;
      rx_frame_data <= 32'd0;
      rx_frame_vld  <= 1'b0;
      rx_crc_err    <= 1'b0;
      rx_err        <= 1'b0;
      rx_sync_lock  <= 1'b0;
    end else begin
      state         <= state_nx;
      idx           <= idx_nx;
      crc           <= crc_nx;
      status_r      <= status_nx;
      data_r        <= data_nx;
      rx_frame_data <= frame_nx;
      rx_frame_vld  <= vld_nx;
      rx_crc_err    <= crc_err_nx;
      rx_err        <= err_nx;
      rx_sync_lock  <= lock_nx;
    end
  end

endmodule

// File: doc/sent_rx_decoder.md
Name: sent_rx_decoder

Overview:
SENT receive/decode stage that sits directly downstream of the SENT frame generator. It consumes one SENT line (loopback of a generator output or an external sensor) and measures falling-edge-to-falling-edge intervals in ticks. It reconstructs status, six data nibbles and the CRC nibble, checks the CRC, and presents the result as a 32-bit word in the same layout as the generator's frame data input, so the word can be reported back upstream.

Parameters:
CLK_FREQ, 100000000, module clock frequency in Hz; must be a multiple of 1000000.
SYNC_TOL, 1, accepted sync deviation in ticks; sync is valid when ticks are in 56±SYNC_TOL.

Ports:
clk  input  1  module clock
rst  input  1  asynchronous reset, active-low
sent_ctick_len  input  8  tick length in us (3..90); 0 disables the decoder
sent_crc_mode  input  1  0 = legacy CRC, 1 = recommended CRC (extra zero nibble)
sent_in  input  1  asynchronous SENT line, idle high
rx_frame_vld  output  1  one-cycle pulse, decoded frame valid
rx_frame_data  output  32  [31:28] status, [27:4] data nibbles 1..6 (nibble 1 at [27:24]), [3:0] received CRC
rx_crc_err  output  1  one-cycle pulse, coincident with rx_frame_vld when the CRC mismatches
rx_err  output  1  one-cycle pulse on a framing error (bad nibble or timeout inside a frame)
rx_sync_lock  output  1  high from the first accepted sync until the next error, timeout or disable

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; rx_frame_data=0; synchroniser FFs=1; state HUNT; counters 0.
- Input path: 2-FF synchroniser, then a registered falling-edge detect. A falling edge is seen 3 clk after the sent_in edge.
- Tick timebase: TICK_CYC = sent_ctick_len * (CLK_FREQ/1000000), 16 bits.
- sub_cnt counts 0..TICK_CYC-1; on wrap, tick_cnt (10 bits, saturating at 1023) increments.
- On each detected falling edge: latch T = tick_cnt, then set tick_cnt=0 and sub_cnt=TICK_CYC/2 (floor). This makes T the rounded interval.
- Nibble valid: 12<=T<=27, value = T-12. Sync valid: |T-56|<=SYNC_TOL.
- States (evaluated on each falling edge, using T):
  - HUNT: sync valid -> STATUS, rx_sync_lock=1, CRC accumulator=4'd5. Otherwise stay; no error.
  - STATUS: valid nibble -> store status, DATA with idx=0.
  - DATA: valid nibble -> store nibble idx and update CRC; at idx=5 -> CRC_NIB, else idx+1.
  - CRC_NIB: valid nibble -> store received CRC, emit frame -> POST.
  - POST: sync valid -> STATUS (no pause, next frame). Any other T -> HUNT (treated as pause).
  - In STATUS/DATA/CRC_NIB, an invalid nibble pulses rx_err and clears rx_sync_lock. If that T is sync valid -> STATUS (resync, CRC reseeded), else -> HUNT.
- CRC: table {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}; per data nibble crc = nib ^ tbl[crc]. Status nibble is excluded.
- In recommended mode, after nibble 6 apply crc = tbl[crc]. Compare with the received CRC.
- Output timing: rx_frame_vld, rx_frame_data and rx_crc_err update 4 clk after the sent_in falling edge that ends the CRC nibble.
- rx_frame_data holds its value until the next frame. A frame is output even on CRC mismatch.
- Timeout: tick_cnt reaching 1023 outside HUNT/POST pulses rx_err once, clears rx_sync_lock, and goes to HUNT. In POST it goes to HUNT silently. The line stuck high or low is handled the same way.
- sent_ctick_len and sent_crc_mode are sampled into registers. A change to either, or sent_ctick_len=0, forces HUNT, clears rx_sync_lock and clears counters, with no rx_err.
- rx_err and rx_frame_vld never assert in the same cycle.
- Reset mid-frame: immediate return to the reset state. The first interval after reset is never decoded as data.

Test Plan:
1. CLK_FREQ=100M, ctick=3 (TICK_CYC=300), legacy mode: sync, status 0, nibbles 1..6, CRC 13 -> one rx_frame_vld, rx_frame_data=32'h0123456D, rx_crc_err=0, 4 clk after the final edge.
2. Same frame in recommended mode with CRC 2 -> rx_frame_data=32'h01234562, no crc_err. Resend with CRC 3 -> rx_frame_data=32'h01234563, rx_crc_err=1.
3. Back-to-back frames without pause, then frames with a 20-tick pause, intervals jittered ±140 clk -> every frame decoded, rx_sync_lock stays 1.
4. Nibble interval of 30 ticks mid-data -> rx_err pulse, rx_sync_lock=0, no frame. A 56-tick interval next -> resync and the following frame decodes.
5. Line held low for 1100 ticks mid-frame -> single rx_err at tick 1023, state HUNT. sent_ctick_len changed mid-frame -> HUNT, no rx_err, no frame.
6. rst asserted mid-DATA -> all outputs 0 immediately. After release, the first full frame decodes correctly.
